hdmux_dispatcher: RTL and testbench



---
 rtl/hdmux_dispatcher.sv | 113 +++++++++++
 tb/tb_hdmux_dispatcher.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmux_dispatcher.sv
// hDMux dispatcher: single-slot holding register steering each accepted word to one of WAYS lanes.
// Optional per-lane saturating delivery counters when HDMUX_DISPATCH_COUNT_EN is defined.
module hdmux_dispatcher #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 4,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    rr_mode,
  output logic [WAYS*WIDTH-1:0]   out_data,
  output logic [WAYS-1:0]         out_valid,
  input  logic [WAYS-1:0]         out_ready,
  output logic [SEL_W-1:0]        cur_sel,
`ifdef HDMUX_DISPATCH_COUNT_EN
  output logic [WAYS*8-1:0]       deliv_cnt,
`endif
  output logic                    busy
);

  // Handshake: a word moves across an interface on a rising edge where valid and ready
  // are both high; valid never depends on ready, and out_valid/out_data stay frozen while waiting.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_q;
  logic [WIDTH-1:0]        hold_q;
  logic [SEL_W-1:0]        sel_q;
  logic [SEL_W-1:0]        rr_q;
  logic [WAYS-1:0]         ovalid_q;
  logic [WAYS*WIDTH-1:0]   odata_q;

  logic                    accept;
  logic                    deliver;
  logic [SEL_W-1:0]        lane_d;
  logic [WAYS-1:0]         ovalid_d;
  logic [WAYS*WIDTH-1:0]   odata_d;

  assign in_ready = (state_q == EMPTY) || out_ready[sel_q];
  assign accept   = in_valid && in_ready;
  assign deliver  = (state_q == FULL) && out_ready[sel_q];
  assign lane_d   = rr_mode ? rr_q : in_sel;

  // Pre-decode the lane image of an incoming word so outputs can be registered directly.
  always_comb begin
    ovalid_d = '0;
    odata_d  = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (lane_d == SEL_W'(i)) begin
        ovalid_d[i]                = 1'b1;
        odata_d[i*WIDTH +: WIDTH]  = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      hold_q   <= '0;
      sel_q    <= '0;
      rr_q     <= '0;
      ovalid_q <= '0;
      odata_q  <= '0;
    end else begin
      case (state_q)
        EMPTY, FULL: begin
          if (accept) begin
            state_q  <= FULL;
            hold_q   <= in_data;
            sel_q    <= lane_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            if (rr_mode) rr_q <= rr_q + 1'b1;
          end else if (deliver) begin
            state_q  <= EMPTY;
            hold_q   <= '0;
            sel_q    <= '0;
            ovalid_q <= '0;
            odata_q  <= '0;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign cur_sel   = sel_q;
  assign busy      = (state_q == FULL);

`ifdef HDMUX_DISPATCH_COUNT_EN
  logic [WAYS*8-1:0] cnt_q;

  // Counters stick at 255 rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (deliver && (sel_q == SEL_W'(i)) && (cnt_q[i*8 +: 8] != 8'hFF))
          cnt_q[i*8 +: 8] <= cnt_q[i*8 +: 8] + 8'd1;
      end
    end
  end

  assign deliv_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hdmux_dispatcher.sv
// Directed bench for hdmux_dispatcher (WIDTH=16, WAYS=4); counter checks run when
// HDMUX_DISPATCH_COUNT_EN is defined.
module tb_hdmux_dispatcher;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        rr_mode;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  cur_sel;
  logic        busy;
`ifdef HDMUX_DISPATCH_COUNT_EN
  logic [31:0] deliv_cnt;
`endif

  int total = 0;
  int bad   = 0;

  hdmux_dispatcher #(.WIDTH(16), .WAYS(4), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel),
`ifdef HDMUX_DISPATCH_COUNT_EN
    .deliv_cnt (deliv_cnt),
`endif
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    rr_mode   = 1'b0;
    out_ready = 4'hF;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  out_data, 64'h0);
    chk("rst_busy",      64'(busy), 64'h0);
    chk("rst_cur_sel",   64'(cur_sel), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Addressed word to lane 2
    in_data = 16'hABCD; in_sel = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("addr_valid",   64'(out_valid), 64'h4);
    chk("addr_data",    out_data, 64'h0000_ABCD_0000_0000);
    chk("addr_cur_sel", 64'(cur_sel), 64'h2);
    chk("addr_busy",    64'(busy), 64'h1);
    tick();
    chk("addr_empty_busy",  64'(busy), 64'h0);
    chk("addr_empty_valid", 64'(out_valid), 64'h0);
    chk("addr_empty_sel",   64'(cur_sel), 64'h0);

    // Round-robin stream 1..5, lanes 0,1,2,3,0
    rr_mode = 1'b1; in_valid = 1'b1; in_data = 16'h0001;
    tick();
    chk("rr1_valid", 64'(out_valid), 64'h1);
    chk("rr1_data",  out_data, 64'h0000_0000_0000_0001);
    chk("rr1_ready", 64'(in_ready), 64'h1);
    in_data = 16'h0002;
    tick();
    chk("rr2_valid", 64'(out_valid), 64'h2);
    chk("rr2_data",  out_data, 64'h0000_0000_0002_0000);
    in_data = 16'h0003;
    tick();
    chk("rr3_valid", 64'(out_valid), 64'h4);
    chk("rr3_data",  out_data, 64'h0000_0003_0000_0000);
    in_data = 16'h0004;
    tick();
    chk("rr4_valid", 64'(out_valid), 64'h8);
    chk("rr4_data",  out_data, 64'h0004_0000_0000_0000);
    in_data = 16'h0005;
    tick();
    chk("rr5_wrap_valid", 64'(out_valid), 64'h1);
    chk("rr5_wrap_data",  out_data, 64'h0000_0000_0000_0005);
    in_valid = 1'b0;
    tick();
    chk("rr_drain_busy", 64'(busy), 64'h0);

    // Backpressure on lane 1 with the next word waiting
    rr_mode = 1'b0; in_sel = 2'd1; out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'h2);
      chk("bp_hold_data",  out_data, 64'h0000_0000_1111_0000);
      chk("bp_hold_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 4'hF;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    chk("bp_next_valid", 64'(out_valid), 64'h2);
    chk("bp_next_data",  out_data, 64'h0000_0000_2222_0000);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_busy", 64'(busy), 64'h0);

    // Mid-flight asynchronous reset (rr_ptr is 1 at this point)
    in_sel = 2'd3; in_data = 16'h5A5A; in_valid = 1'b1; out_ready = 4'h0;
    tick();
    in_valid = 1'b0;
    chk("mr_held_valid", 64'(out_valid), 64'h8);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_valid", 64'(out_valid), 64'h0);
    chk("mr_async_data",  out_data, 64'h0);
    chk("mr_async_busy",  64'(busy), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 4'hF; rr_mode = 1'b1; in_valid = 1'b1; in_data = 16'h0007;
    tick();
    in_valid = 1'b0;
    chk("mr_rr_restart_valid", 64'(out_valid), 64'h1);
    chk("mr_rr_restart_data",  out_data, 64'h0000_0000_0000_0007);
    tick();

    // Mode change while FULL (rr_ptr is 1)
    out_ready = 4'h0; in_valid = 1'b1; in_data = 16'h000B;
    tick();
    in_valid = 1'b0; rr_mode = 1'b0; in_sel = 2'd3;
    tick();
    chk("mode_hold_valid", 64'(out_valid), 64'h2);
    chk("mode_hold_data",  out_data, 64'h0000_0000_000B_0000);
    out_ready = 4'hF; in_valid = 1'b1; in_data = 16'h000C;
    tick();
    chk("mode_addr_valid", 64'(out_valid), 64'h8);
    chk("mode_addr_data",  out_data, 64'h000C_0000_0000_0000);
    rr_mode = 1'b1; in_data = 16'h000D;
    tick();
    chk("mode_rr_ptr_kept", 64'(out_valid), 64'h4);
    chk("mode_rr_data",     out_data, 64'h0000_000D_0000_0000);
    in_valid = 1'b0;
    tick();

`ifdef HDMUX_DISPATCH_COUNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_clear", 64'(deliv_cnt), 64'h0);
    rr_mode = 1'b0; in_sel = 2'd0; out_ready = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("cnt_saturate", 64'(deliv_cnt), 64'h0000_00FF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("cnt_rst", 64'(deliv_cnt), 64'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
